am_modulator: RTL and testbench

Digital AM modulator stage directly downstream of the three-channel DDS block. It takes the carrier and the two baseband tones (1 kHz, 5 kHz) as 8-bit two's-complement samples and forms s = (128 + k·x/256) · carrier. Modulation index k and baseband select are reconfigured only at a carrier upward zero-crossing, so the envelope never glitches mid-cycle. The 16-bit result feeds the DAC path and the demodulator.

---
 rtl/am_pkg.sv | 31 +++
 rtl/am_cfg_ctrl.sv | 94 +++++++++
 rtl/am_modulator.sv | 142 ++++++++++++++
 tb/tb_am_modulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
`default_nettype none
// ============================================================================
// Module   : am_pkg
// Brief    : Shared constants and types for the AM modulator stage.
// Revision : 1.0 - initial release
// ============================================================================
package am_pkg;

  // Default sample width of carrier and baseband inputs
  localparam int DW_DEF = 8;

  // Baseband select encodings
  localparam logic [1:0] SEL_J1  = 2'b00;
  localparam logic [1:0] SEL_J2  = 2'b01;
  localparam logic [1:0] SEL_SUM = 2'b10;
  localparam logic [1:0] SEL_OFF = 2'b11;

  // Modulation index after reset (k/256 = 0.5)
  localparam logic [7:0] K_RESET = 8'd128;

  // Envelope DC offset added to the scaled baseband
  localparam int ENV_OFFSET = 128;

  // Config-apply controller states
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/am_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : am_cfg_ctrl
// Brief    : Holds a requested (sel, k) in shadow registers and applies it at
//            the next carrier upward zero-crossing, or after a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module am_cfg_ctrl
  import am_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       i_in_valid,
  input  logic       i_carrier_neg,
  input  logic       i_cfg_valid,
  input  logic [1:0] i_cfg_sel,
  input  logic [7:0] i_cfg_k,
  output logic       o_cfg_ready,
  output logic [1:0] o_sel_act,
  output logic [7:0] o_k_act
);

  // Timer value one below all-ones: the increment from here reaches the limit
  localparam logic [TO_W-1:0] C_TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  cfg_state_e      r_state;
  logic [TO_W-1:0] r_timer;
  logic [1:0]      r_sel_sh;
  logic [7:0]      r_k_sh;
  logic [1:0]      r_sel_act;
  logic [7:0]      r_k_act;
  logic            r_cfg_ready;
  logic            r_prev_neg;

  logic w_cross;
  logic w_timeout;

  // Upward crossing: this valid sample non-negative, previous valid one negative
  assign w_cross   = i_in_valid & ~i_carrier_neg & r_prev_neg;
  assign w_timeout = (r_timer == C_TO_LAST);

  // Config FSM with shadow/active registers, crossing history and timeout timer
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_sel_sh    <= SEL_J1;
      r_k_sh      <= K_RESET;
      r_sel_act   <= SEL_J1;
      r_k_act     <= K_RESET;
      r_cfg_ready <= 1'b1;
      r_prev_neg  <= 1'b0;
    end else begin
      if (i_in_valid) begin
        r_prev_neg <= i_carrier_neg;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            r_sel_sh    <= i_cfg_sel;
            r_k_sh      <= i_cfg_k;
            r_timer     <= '0;
            r_cfg_ready <= 1'b0;
            r_state     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          // A crossing and a timeout in the same cycle collapse into one apply
          if (w_cross || w_timeout) begin
            r_sel_act   <= r_sel_sh;
            r_k_act     <= r_k_sh;
            r_timer     <= '0;
            r_cfg_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cfg_ready = r_cfg_ready;
  assign o_sel_act   = r_sel_act;
  assign o_k_act     = r_k_act;

endmodule
`default_nettype wire

// File: rtl/am_modulator.sv
`default_nettype none
// ============================================================================
// Module   : am_modulator
// Brief    : 4-stage AM modulator, am_out = (128 + k*x/256) * carrier, with
//            glitch-free config changes applied at carrier zero-crossings.
// Revision : 1.0 - initial release
// ============================================================================
module am_modulator
  import am_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int TO_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic signed [DW-1:0] carrier,
  input  logic signed [DW-1:0] jidai1,
  input  logic signed [DW-1:0] jidai2,
  input  logic                 in_valid,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_sel,
  input  logic [7:0]           cfg_k,
  output logic signed [2*DW-1:0] am_out,
  output logic                 out_valid
);

  logic [1:0] w_sel_act;
  logic [7:0] w_k_act;

  am_cfg_ctrl #(
    .TO_W (TO_W)
  ) u_cfg (
    .clk_in        (clk_in),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .i_carrier_neg (carrier[DW-1]),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_sel     (cfg_sel),
    .i_cfg_k       (cfg_k),
    .o_cfg_ready   (cfg_ready),
    .o_sel_act     (w_sel_act),
    .o_k_act       (w_k_act)
  );

  // Pipeline registers
  logic                 r_v0, r_v1, r_v2;
  logic signed [DW-1:0] r_x0, r_c0, r_c1, r_c2;
  logic [7:0]           r_k0;
  logic signed [DW:0]   r_m1;
  logic [DW-1:0]        r_e2;

  logic signed [DW:0]      w_sum;
  logic signed [DW-1:0]    w_x;
  logic signed [DW+8:0]    w_prod;
  logic signed [DW:0]      w_env;
  logic signed [2*DW:0]    w_am;
  logic                    w_unused;

  // Sum mode halves a full-width add, so the result always fits DW bits
  assign w_sum = {jidai1[DW-1], jidai1} + {jidai2[DW-1], jidai2};

  // Baseband select for the incoming sample using the active config
  always_comb begin
    w_x = '0;
    case (w_sel_act)
      SEL_J1:  w_x = jidai1;
      SEL_J2:  w_x = jidai2;
      SEL_SUM: w_x = w_sum[DW:1];
      default: w_x = '0;
    endcase
  end

  // k is unsigned, so a zero MSB makes it a non-negative signed operand
  assign w_prod = $signed({1'b0, r_k0}) * r_x0;
  assign w_env  = r_m1 + $signed((DW+1)'(ENV_OFFSET));
  assign w_am   = $signed({1'b0, r_e2}) * r_c2;

  // Discarded bits: product fraction, envelope/result sign-extension, sum LSB
  assign w_unused = ^{w_prod[7:0], w_env[DW], w_am[2*DW], w_sum[0]};

  // Valid shift chain; runs every cycle so gaps propagate as out_valid=0
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_v0      <= 1'b0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      r_v0      <= in_valid;
      r_v1      <= r_v0;
      r_v2      <= r_v1;
      out_valid <= r_v2;
    end
  end

  // S0: capture selected baseband with the carrier and k it must be paired with
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_x0 <= '0;
      r_c0 <= '0;
      r_k0 <= K_RESET;
    end else if (in_valid) begin
      r_x0 <= w_x;
      r_c0 <= carrier;
      r_k0 <= w_k_act;
    end
  end

  // S1: m = floor(k*x / 256)
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_m1 <= '0;
      r_c1 <= '0;
    end else if (r_v0) begin
      r_m1 <= w_prod[DW+8:8];
      r_c1 <= r_c0;
    end
  end

  // S2: envelope e = 128 + m, always non-negative
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_e2 <= '0;
      r_c2 <= '0;
    end else if (r_v1) begin
      r_e2 <= w_env[DW-1:0];
      r_c2 <= r_c1;
    end
  end

  // S3: modulated output e * carrier
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      am_out <= '0;
    end else if (r_v2) begin
      am_out <= w_am[2*DW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_am_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_modulator
// Brief    : Directed bench for am_modulator with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am_modulator;

  logic              clk_in;
  logic              rst;
  logic signed [7:0] carrier;
  logic signed [7:0] jidai1;
  logic signed [7:0] jidai2;
  logic              in_valid;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_sel;
  logic [7:0]        cfg_k;
  logic signed [15:0] am_out;
  logic              out_valid;

  int n_vec = 0;
  int n_err = 0;
  int q_exp[$];

  am_modulator #(
    .DW   (8),
    .TO_W (4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .carrier   (carrier),
    .jidai1    (jidai1),
    .jidai2    (jidai2),
    .in_valid  (in_valid),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_k     (cfg_k),
    .am_out    (am_out),
    .out_valid (out_valid)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // One-cycle sample with its expected output queued
  task automatic send(input int c, input int j1, input int j2, input int exp);
    carrier  = 8'(c);
    jidai1   = 8'(j1);
    jidai2   = 8'(j2);
    in_valid = 1'b1;
    q_exp.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic request(input logic [1:0] sel, input logic [7:0] k);
    cfg_sel   = sel;
    cfg_k     = k;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cfg_ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, int'(cfg_ready), 1);
  endtask

  // Output monitor: every out_valid must match the next queued expectation
  always @(negedge clk_in) begin
    if (out_valid) begin
      if (q_exp.size() == 0) chk("spurious_out_valid", int'(out_valid), 0);
      else chk("am_out", int'(am_out), q_exp.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; carrier = '0; jidai1 = '0; jidai2 = '0;
    in_valid = 1'b0; cfg_valid = 1'b0; cfg_sel = 2'b00; cfg_k = 8'd0;
    repeat (3) tick();
    chk("rst_am_out", int'(am_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    rst = 1'b1;
    tick();

    // Stream of 6 samples; reset lands while samples 3..6 are in flight
    // k=128, x=60: m=30, e=158, 158*30=4740
    carrier = 8'sd30; jidai1 = 8'sd60; jidai2 = 8'sd0; in_valid = 1'b1;
    q_exp.push_back(4740);
    q_exp.push_back(4740);
    repeat (6) tick();
    chk("pre_rst_am_out", int'(am_out), 4740);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_am_out", int'(am_out), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    send(50, 0, 0, 6400);
    idle(6);

    // Timeout apply of k=255 with carrier held at +10 (x=0 -> 128*10)
    cfg_sel = 2'b00; cfg_k = 8'd255; cfg_valid = 1'b1;
    carrier = 8'sd10; jidai1 = 8'sd0; in_valid = 1'b1;
    q_exp.push_back(1280);
    tick();
    cfg_valid = 1'b0;
    chk("to_ready_low", int'(cfg_ready), 0);
    n = 0;
    while (!cfg_ready && n < 40) begin
      q_exp.push_back(1280);
      tick();
      n++;
    end
    chk("to_latency", n, 15);
    idle(6);

    // Peak: m=126, e=254, 254*100
    carrier = 8'sd100; jidai1 = 8'sd127; in_valid = 1'b1;
    q_exp.push_back(25400);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("peak_latency", n, 4);
    tick();
    chk("peak_pulse_width", int'(out_valid), 0);
    idle(4);

    // Trough: m=-128, e=0
    send(100, -128, 0, 0);
    idle(6);

    // Sum mode, k=128 via timeout: x=25, m=12, e=140, 140*-10
    request(2'b10, 8'd128);
    wait_ready("sum_apply");
    send(-10, 100, -50, -1400);
    idle(6);

    // Crossing apply of k=64 sel=00; both old and new select give x=100
    // old k=128: e=178; new k=64: e=153
    request(2'b00, 8'd64);
    chk("x_ready_low", int'(cfg_ready), 0);
    cfg_sel = 2'b11; cfg_k = 8'd200; cfg_valid = 1'b1;
    send(-5, 100, 100, -890);
    chk("x_ignore_ready", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    send(-3, 100, 100, -534);
    chk("x_neg2_ready", int'(cfg_ready), 0);
    send(2, 100, 100, 356);
    chk("x_apply_ready", int'(cfg_ready), 1);
    send(2, 100, 100, 306);
    idle(6);
    // Ignored request (sel=11,k=200) would give 128*4=512
    send(4, 100, 0, 612);
    idle(6);

    // Reset while PENDING discards the shadow and restores k=128
    request(2'b01, 8'd0);
    chk("rp_ready_low", int'(cfg_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rp_ready_rst", int'(cfg_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("rp_ready_after", int'(cfg_ready), 1);
    // k=128, x=127: m=63, e=191
    send(100, 127, 0, 19100);
    idle(25);
    send(100, 127, 0, 19100);
    idle(6);

    chk("drain", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
